// File: rtl/sys_array_result_streamer_pkg.sv
// Shared types for the result streamer: run modes, FSM states and element type.
package sys_array_pkg;

  typedef enum logic [1:0] {
    M_STREAM  = 2'd0,
    M_LOOP    = 2'd1,
    M_STEP    = 2'd2,
    M_ONESHOT = 2'd3
  } stream_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_HOLD,
    S_STEPWAIT,
    S_DONE
  } rs_state_t;

  localparam int RS_DATA_WIDTH = 8;
  typedef logic [2*RS_DATA_WIDTH-1:0] result_t;

  // Index/counter width that stays legal for a dimension of 1.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_array_result_streamer_if.sv
// Capture inputs and element readout of the streamer; master = streamer, slave = fetcher/display side.
interface sys_array_result_streamer_if
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 5,
  parameter int COLS       = 5
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  logic                                          result_valid;
  logic [0:ROWS-1][0:COLS-1][2*DATA_WIDTH-1:0]   result_data;
  logic [1:0]                                    mode;
  logic                                          col_major;
  logic                                          step;
  logic                                          out_ready;
  logic                                          out_valid;
  logic [2*DATA_WIDTH-1:0]                       out_data;
  logic [RW-1:0]                                 out_row;
  logic [CW-1:0]                                 out_col;
  logic                                          out_last;
  logic                                          busy;
  logic                                          done;
  logic                                          overrun;

  modport master (
    input  result_valid, result_data, mode, col_major, step, out_ready,
    output out_valid, out_data, out_row, out_col, out_last, busy, done, overrun
  );

  modport slave (
    output result_valid, result_data, mode, col_major, step, out_ready,
    input  out_valid, out_data, out_row, out_col, out_last, busy, done, overrun
  );
endinterface

// File: rtl/sys_array_index_walker.sv
// Row/column walker over a ROWS x COLS matrix; wraps to (0,0) after the last element.
module sys_array_index_walker
  import sys_array_pkg::*;
#(
  parameter int  ROWS = 5,
  parameter int  COLS = 5,
  localparam int RW   = idx_w(ROWS),
  localparam int CW   = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          col_major_i,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          last_q;

  wire row_end = (row_q == RW'(ROWS-1));
  wire col_end = (col_q == CW'(COLS-1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (!col_major_i) begin
        col_d = col_end ? '0 : col_q + CW'(1);
        if (col_end) row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        row_d = row_end ? '0 : row_q + RW'(1);
        if (row_end) col_d = col_end ? '0 : col_q + CW'(1);
      end
    end
  end

  // last is registered from the next index so it lines up with row/col.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q  <= '0;
      col_q  <= '0;
      last_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      last_q <= (row_d == RW'(ROWS-1)) && (col_d == CW'(COLS-1));
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = last_q;
endmodule

// File: rtl/sys_array_result_streamer.sv
// Snapshots the result matrix on a result_valid rise and presents it element by element.
module sys_array_result_streamer
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ROWS        = 5,
  parameter int COLS        = 5,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  sys_array_result_streamer_if.master  bus
);
  localparam int W  = 2*DATA_WIDTH;
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam int HW = idx_w(HOLD_CYCLES);

  rs_state_t                        st_q;
  stream_mode_t                     mode_q;
  logic                             cm_q, rv_q, vld_q, busy_q, done_q, ovr_q;
  logic [HW-1:0]                    dwell_q;
  logic [0:ROWS-1][0:COLS-1][W-1:0] buf_q;
  logic [RW-1:0]                    row;
  logic [CW-1:0]                    col;
  logic                             last, cap, accept, adv, dwell_end;

  assign cap       = bus.result_valid & ~rv_q;
  assign dwell_end = (dwell_q == HW'(HOLD_CYCLES-1));

  // A capture only interrupts a pass that never ends on its own (LOOP, STEP).
  always_comb begin
    accept = 1'b0;
    adv    = 1'b0;
    case (st_q)
      S_IDLE, S_DONE, S_STEPWAIT: accept = cap;
      S_HOLD:                     accept = cap & (mode_q == M_LOOP);
      default: ;
    endcase
    if (!accept) begin
      case (st_q)
        S_STREAM:   adv = bus.out_ready;
        S_HOLD:     adv = dwell_end;
        S_STEPWAIT: adv = bus.step;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= S_IDLE;
      mode_q  <= M_STREAM;
      cm_q    <= 1'b0;
      rv_q    <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dwell_q <= '0;
      buf_q   <= '0;
    end else begin
      rv_q <= bus.result_valid;
      if (cap && !accept) ovr_q <= 1'b1;
      if (accept) begin
        buf_q   <= bus.result_data;
        mode_q  <= stream_mode_t'(bus.mode);
        cm_q    <= bus.col_major;
        dwell_q <= '0;
        vld_q   <= 1'b1;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        case (stream_mode_t'(bus.mode))
          M_STREAM: st_q <= S_STREAM;
          M_STEP:   st_q <= S_STEPWAIT;
          default:  st_q <= S_HOLD;
        endcase
      end else begin
        if (st_q == S_HOLD) dwell_q <= dwell_end ? '0 : dwell_q + HW'(1);
        if (adv && last &&
            (st_q == S_STREAM || (st_q == S_HOLD && mode_q == M_ONESHOT))) begin
          st_q   <= S_DONE;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  sys_array_index_walker #(.ROWS(ROWS), .COLS(COLS)) u_walker (
    .clk        (clk),
    .reset_n    (reset_n),
    .col_major_i(cm_q),
    .clear_i    (accept),
    .advance_i  (adv),
    .row_o      (row),
    .col_o      (col),
    .last_o     (last)
  );

  assign bus.out_valid = vld_q;
  assign bus.out_data  = buf_q[row][col];
  assign bus.out_row   = row;
  assign bus.out_col   = col;
  assign bus.out_last  = last & vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrun   = ovr_q;
endmodule
